cnn_argmax_classifier: RTL and testbench

- Parametrised classification back-end for the CNN top level. Replaces the fixed 4-bit categories/one_end result path with an N-class streaming argmax stage.
- Accepts one signed score per class from the final dense layer over a valid/ready stream, then selects the winning class.
- Publishes the winning class index and its score with a one-cycle completion strobe, and keeps a frame counter.
- Also flags malformed score streams.

---
 rtl/cnn_argmax_classifier.sv | 132 +++++++++++++
 tb/tb_cnn_argmax_classifier.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/cnn_argmax_classifier.sv
// Streaming argmax back-end: collects one signed score per class, publishes the
// winning class index and score with a one-cycle strobe, counts frames, flags bad lengths.
module cnn_argmax_classifier #(
   parameter int unsigned N_CLASSES = 10,
   parameter int unsigned SCORE_W   = 16,
   parameter int unsigned CAT_W     = 4,
   parameter int unsigned CNT_W     = 16,
   parameter bit          TIE_HIGH  = 1'b0
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   input  logic               score_valid,
   output logic               score_ready,
   input  logic [SCORE_W-1:0] score_data,
   input  logic               score_last,
   output logic [CAT_W-1:0]   category,
   output logic [SCORE_W-1:0] max_score,
   output logic               one_end,
   output logic               busy,
   output logic [CNT_W-1:0]   frame_cnt,
   output logic               err_len
);

   typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_DONE} state_t;

   state_t state, state_next;

   logic [CAT_W-1:0]          idx;
   logic [CAT_W-1:0]          best_idx;
   logic signed [SCORE_W-1:0] best;
   logic                      first;

   logic                      accept_c;
   logic                      at_end_c;
   logic                      frame_end_c;
   logic                      len_bad_c;
   logic                      take_c;
   logic signed [SCORE_W-1:0] score_s_c;
   logic signed [SCORE_W-1:0] best_next_c;
   logic [CAT_W-1:0]          best_idx_next_c;

   logic                      ready_d;
   logic                      busy_d;
   logic                      one_end_d;

   // Per-beat compare; the first-beat flag avoids needing a most-negative sentinel.
   always_comb begin
      score_s_c       = score_data;
      accept_c        = (state == S_COLLECT) && score_valid;
      at_end_c        = (idx == CAT_W'(N_CLASSES - 1));
      frame_end_c     = accept_c && (at_end_c || score_last);
      len_bad_c       = accept_c && (at_end_c != score_last);
      take_c          = first || (score_s_c > best) || (TIE_HIGH && (score_s_c == best));
      best_next_c     = best;
      best_idx_next_c = best_idx;
      if (accept_c && take_c) begin
         best_next_c     = score_s_c;
         best_idx_next_c = idx;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) state <= S_IDLE;
      else       state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         S_IDLE:    if (start) state_next = S_COLLECT;
         S_COLLECT: if (frame_end_c) state_next = S_DONE;
         S_DONE:    state_next = S_IDLE;
         default:   state_next = S_IDLE;
      endcase
   end

   // Output decode from the next state so the registered outputs line up with the state.
   always_comb begin
      ready_d   = 1'b0;
      busy_d    = 1'b0;
      one_end_d = 1'b0;
      case (state_next)
         S_COLLECT: begin
            ready_d = 1'b1;
            busy_d  = 1'b1;
         end
         S_DONE: begin
            busy_d    = 1'b1;
            one_end_d = 1'b1;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         score_ready <= 1'b0;
         busy        <= 1'b0;
         one_end     <= 1'b0;
         category    <= '0;
         max_score   <= '0;
         frame_cnt   <= '0;
         err_len     <= 1'b0;
         idx         <= '0;
         best_idx    <= '0;
         best        <= '0;
         first       <= 1'b0;
      end else begin
         score_ready <= ready_d;
         busy        <= busy_d;
         one_end     <= one_end_d;
         if (state == S_IDLE && start) begin
            idx   <= '0;
            first <= 1'b1;
         end else if (accept_c) begin
            idx      <= idx + CAT_W'(1);
            first    <= 1'b0;
            best     <= best_next_c;
            best_idx <= best_idx_next_c;
         end
         // Result is captured as the final beat lands so it is visible with one_end.
         if (frame_end_c) begin
            category  <= best_idx_next_c;
            max_score <= best_next_c;
            frame_cnt <= frame_cnt + CNT_W'(1);
         end
         if (len_bad_c) err_len <= 1'b1;
      end
   end

endmodule

// File: tb/tb_cnn_argmax_classifier.sv
// Bench for cnn_argmax_classifier: three instances (low tie, high tie, 2-bit counter)
// share one stimulus stream and are checked against an argmax reference model.
module tb_cnn_argmax_classifier;

   localparam int unsigned N  = 10;
   localparam int unsigned SW = 16;
   localparam int unsigned CW = 4;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          reset = 1'b1, start = 1'b0, score_valid = 1'b0, score_last = 1'b0;
   logic [SW-1:0] score_data = '0;

   logic          r0, r1, r2, oe0, oe1, oe2, b0, b1, b2, e0, e1, e2;
   logic [CW-1:0] c0, c1, c2;
   logic [SW-1:0] m0, m1, m2;
   logic [15:0]   f0, f1;
   logic [1:0]    f2;

   int n_cmp = 0, n_err = 0;
   int exp_f0 = 0, exp_f1 = 0, exp_f2 = 0;
   bit exp_err = 1'b0;
   int exp_lo = 0;
   logic signed [SW-1:0] fr [N];

   cnn_argmax_classifier #(.TIE_HIGH(1'b0)) u0 (
      .clk(clk), .reset(reset), .start(start), .score_valid(score_valid), .score_ready(r0),
      .score_data(score_data), .score_last(score_last), .category(c0), .max_score(m0),
      .one_end(oe0), .busy(b0), .frame_cnt(f0), .err_len(e0));
   cnn_argmax_classifier #(.TIE_HIGH(1'b1)) u1 (
      .clk(clk), .reset(reset), .start(start), .score_valid(score_valid), .score_ready(r1),
      .score_data(score_data), .score_last(score_last), .category(c1), .max_score(m1),
      .one_end(oe1), .busy(b1), .frame_cnt(f1), .err_len(e1));
   cnn_argmax_classifier #(.CNT_W(2)) u2 (
      .clk(clk), .reset(reset), .start(start), .score_valid(score_valid), .score_ready(r2),
      .score_data(score_data), .score_last(score_last), .category(c2), .max_score(m2),
      .one_end(oe2), .busy(b2), .frame_cnt(f2), .err_len(e2));

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset(input int cycles);
      reset = 1'b1; start = 1'b0; score_valid = 1'b0; score_last = 1'b0;
      repeat (cycles) tick();
      reset = 1'b0;
      exp_f0 = 0; exp_f1 = 0; exp_f2 = 0; exp_err = 1'b0; exp_lo = 0;
   endtask

   // Plays fr[] as one frame; last_pos < 0 means score_last never asserted.
   task automatic run_frame(input int last_pos, input bit stall, input bit done_start);
      int nb, lo, hi, t;
      logic signed [SW-1:0] mx;
      nb = (last_pos >= 0 && last_pos < int'(N)) ? last_pos + 1 : int'(N);
      mx = fr[0];
      for (int i = 1; i < nb; i++) if (fr[i] > mx) mx = fr[i];
      lo = -1; hi = 0;
      for (int i = 0; i < nb; i++) if (fr[i] == mx) begin
         if (lo < 0) lo = i;
         hi = i;
      end
      exp_lo = lo;
      exp_f0 = (exp_f0 + 1) % 65536; exp_f1 = (exp_f1 + 1) % 65536; exp_f2 = (exp_f2 + 1) % 4;
      if (last_pos != int'(N) - 1) exp_err = 1'b1;

      start = 1'b1; tick(); start = 1'b0;
      for (int b = 0; b < nb; b++) begin
         if (stall && b > 0) begin
            score_valid = 1'b0; start = 1'b1; tick(); start = 1'b0; tick();
         end
         score_valid = 1'b1; score_data = fr[b]; score_last = (b == last_pos);
         t = 0;
         while (!r0 && t < 20) begin tick(); t++; end
         n_cmp++;
         if (r0 !== 1'b1) begin n_err++; $display("FAIL ready_timeout beat=%0d got=%b want=1", b, r0); end
         tick();
         score_valid = 1'b0; score_last = 1'b0;
         if (b < nb - 1) begin
            n_cmp++;
            if (oe0 !== 1'b0) begin n_err++; $display("FAIL early_one_end beat=%0d got=%b want=0", b, oe0); end
         end
      end
      n_cmp++;
      if (oe0 !== 1'b1 || oe1 !== 1'b1 || oe2 !== 1'b1)
         begin n_err++; $display("FAIL one_end got=%b%b%b want=111", oe0, oe1, oe2); end
      n_cmp++;
      if (c0 !== CW'(lo) || c2 !== CW'(lo))
         begin n_err++; $display("FAIL category_low got=%0d/%0d want=%0d", c0, c2, lo); end
      n_cmp++;
      if (c1 !== CW'(hi)) begin n_err++; $display("FAIL category_high got=%0d want=%0d", c1, hi); end
      n_cmp++;
      if (m0 !== mx || m1 !== mx || m2 !== mx)
         begin n_err++; $display("FAIL max_score got=%0d/%0d/%0d want=%0d", $signed(m0), $signed(m1), $signed(m2), mx); end
      n_cmp++;
      if (f0 !== 16'(exp_f0) || f1 !== 16'(exp_f1) || f2 !== 2'(exp_f2))
         begin n_err++; $display("FAIL frame_cnt got=%0d/%0d/%0d want=%0d/%0d/%0d", f0, f1, f2, exp_f0, exp_f1, exp_f2); end
      n_cmp++;
      if (e0 !== exp_err || e1 !== exp_err || e2 !== exp_err)
         begin n_err++; $display("FAIL err_len got=%b%b%b want=%b", e0, e1, e2, exp_err); end
      if (done_start) start = 1'b1;
      tick();
      start = 1'b0;
      n_cmp++;
      if (oe0 !== 1'b0 || b0 !== 1'b0 || r0 !== 1'b0 || b1 !== 1'b0)
         begin n_err++; $display("FAIL after_done one_end=%b busy=%b ready=%b want=000", oe0, b0, r0); end
      n_cmp++;
      if (c0 !== CW'(lo)) begin n_err++; $display("FAIL category_hold got=%0d want=%0d", c0, lo); end
      tick();
      n_cmp++;
      if (b0 !== 1'b0) begin n_err++; $display("FAIL idle_after_done busy got=%b want=0", b0); end
   endtask

   task automatic test_reset();
      do_reset(3);
      n_cmp++;
      if ({c0, m0, oe0, b0, r0, f0, e0} !== '0 || {r1, r2, b2, f2, e2} !== '0)
         begin n_err++; $display("FAIL reset_state cat=%0d max=%0d oe=%b busy=%b rdy=%b cnt=%0d err=%b want=0",
                                 c0, m0, oe0, b0, r0, f0, e0); end
   endtask

   task automatic load_basic();
      int v [N] = '{5, -3, 12, 7, 0, 1, 2, 3, 4, 11};
      for (int i = 0; i < int'(N); i++) fr[i] = SW'(v[i]);
   endtask

   task automatic test_basic();
      load_basic();
      run_frame(9, 1'b0, 1'b0);
      n_cmp++;
      if (c0 !== 4'd2 || m0 !== 16'd12 || f0 !== 16'd1 || e0 !== 1'b0)
         begin n_err++; $display("FAIL basic_const cat=%0d max=%0d cnt=%0d err=%b want=2/12/1/0", c0, m0, f0, e0); end
   endtask

   task automatic test_ties();
      for (int i = 0; i < int'(N); i++) fr[i] = 16'sd100;
      run_frame(9, 1'b0, 1'b0);
      n_cmp++;
      if (c0 !== 4'd0 || c1 !== 4'd9)
         begin n_err++; $display("FAIL tie_const got=%0d/%0d want=0/9", c0, c1); end
   endtask

   task automatic test_negative();
      for (int i = 0; i < int'(N); i++) fr[i] = 16'sh8000;
      fr[6] = 16'sh8001;
      run_frame(9, 1'b0, 1'b0);
      n_cmp++;
      if (c0 !== 4'd6 || m0 !== 16'h8001)
         begin n_err++; $display("FAIL neg_one got=%0d/%0d want=6/-32767", c0, $signed(m0)); end
      fr[6] = 16'sh8000;
      run_frame(9, 1'b0, 1'b0);
      n_cmp++;
      if (c0 !== 4'd0 || m0 !== 16'h8000)
         begin n_err++; $display("FAIL neg_all got=%0d/%0d want=0/-32768", c0, $signed(m0)); end
   endtask

   task automatic test_stall();
      load_basic();
      run_frame(9, 1'b1, 1'b1);
      n_cmp++;
      if (c0 !== 4'd2 || m0 !== 16'd12)
         begin n_err++; $display("FAIL stall_const got=%0d/%0d want=2/12", c0, m0); end
   endtask

   task automatic test_length_errors();
      do_reset(2);
      load_basic();
      fr[9] = 16'sd500;
      run_frame(4, 1'b0, 1'b0);
      n_cmp++;
      if (c0 !== 4'd2 || e0 !== 1'b1)
         begin n_err++; $display("FAIL short_frame cat=%0d err=%b want=2/1", c0, e0); end
      run_frame(-1, 1'b0, 1'b0);
      n_cmp++;
      if (c0 !== 4'd9 || e0 !== 1'b1 || f0 !== 16'd2)
         begin n_err++; $display("FAIL nolast_frame cat=%0d err=%b cnt=%0d want=9/1/2", c0, e0, f0); end
   endtask

   task automatic test_reset_mid();
      load_basic();
      run_frame(9, 1'b0, 1'b0);
      start = 1'b1; tick(); start = 1'b0;
      for (int b = 0; b < 5; b++) begin
         score_valid = 1'b1; score_data = SW'(1000 + b); tick();
      end
      score_valid = 1'b0;
      n_cmp++;
      if (oe0 !== 1'b0 || b0 !== 1'b1)
         begin n_err++; $display("FAIL mid_frame one_end=%b busy=%b want=0/1", oe0, b0); end
      reset = 1'b1; tick(); reset = 1'b0;
      exp_f0 = 0; exp_f1 = 0; exp_f2 = 0; exp_err = 1'b0;
      n_cmp++;
      if (oe0 !== 1'b0 || c0 !== 4'd0 || f0 !== 16'd0 || b0 !== 1'b0 || m0 !== 16'd0)
         begin n_err++; $display("FAIL reset_mid one_end=%b cat=%0d cnt=%0d busy=%b want=0", oe0, c0, f0, b0); end
      load_basic();
      run_frame(9, 1'b0, 1'b0);
   endtask

   task automatic test_wrap();
      int wexp [5] = '{1, 2, 3, 0, 1};
      do_reset(2);
      for (int k = 0; k < 5; k++) begin
         for (int i = 0; i < int'(N); i++) fr[i] = SW'($urandom);
         run_frame(9, 1'b0, 1'b0);
         n_cmp++;
         if (f2 !== 2'(wexp[k])) begin n_err++; $display("FAIL wrap frame=%0d got=%0d want=%0d", k, f2, wexp[k]); end
      end
   endtask

   task automatic test_random();
      int lp;
      for (int k = 0; k < 12; k++) begin
         for (int i = 0; i < int'(N); i++)
            fr[i] = (k % 2 == 0) ? SW'(int'($urandom_range(0, 6)) - 3) : SW'($urandom);
         case ($urandom_range(0, 3))
            0:       lp = -1;
            1:       lp = int'($urandom_range(0, 8));
            default: lp = 9;
         endcase
         run_frame(lp, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_ties();
      test_negative();
      test_stall();
      test_length_errors();
      test_reset_mid();
      test_wrap();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
